// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment message scheduler.
package ssd_pkg;

    // 5-bit character code understood by pmodSSD_Interface.
    typedef logic [4:0] cc_t;

    // Code that renders as an unlit digit.
    localparam cc_t BLANK_CC = 5'h10;

    // Two-digit message: d1 is the left digit, d0 the right digit.
    typedef struct packed {
        cc_t d1;
        cc_t d0;
    } msg_t;

    localparam msg_t BLANK_MSG = '{d1: BLANK_CC, d0: BLANK_CC};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } sched_state_t;

endpackage

// File: rtl/ssd_msg_scheduler_rr_arbiter.sv
// Round-robin selector: searches from last_granted+1 (mod NREQ) and picks
// the first asserted request. Purely combinational.
module rr_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_granted,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   index,
    output logic            any
);

    int unsigned cand;

    // Walk the ring once starting just after the previous winner.
    always_comb begin
        winner = '0;
        index  = '0;
        any    = 1'b0;
        cand   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last_granted) + k) % NREQ;
            if (!any && req[cand]) begin
                any          = 1'b1;
                winner[cand] = 1'b1;
                index        = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/ssd_msg_scheduler.sv
// Message scheduler in front of pmodSSD_Interface: arbitrates round-robin
// between NREQ requesters and holds the winner's two-digit message on the
// display for HOLD_CYCLES clocks. req/req_cc pass through one sampling
// register, so a request seen at edge n is granted at edge n+1.
module ssd_msg_scheduler
    import ssd_pkg::*;
#(
    parameter int SIMULATE    = 0,
    parameter int NREQ        = 3,
    parameter int HOLD_CYCLES = (SIMULATE != 0) ? 16 : 50_000_000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*10-1:0]      req_cc,
    input  logic                    flush,
    output logic [4:0]              digit1,
    output logic [4:0]              digit0,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int unsigned IW   = $clog2(NREQ);
    localparam int unsigned CW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    sched_state_t        state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    msg_t                msg_q, msg_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                busy_q, busy_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       last_q, last_d;
    logic [NREQ-1:0]     req_s_q, req_s_d;
    logic [NREQ*10-1:0]  cc_s_q, cc_s_d;

    logic [NREQ-1:0]     arb_win;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;
    msg_t                sel_msg;
    logic                do_grant;
    logic                go_idle;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req          (req_s_q),
        .last_granted (last_q),
        .winner       (arb_win),
        .index        (arb_idx),
        .any          (arb_any)
    );

    // Pick the sampled message belonging to the current arbitration winner.
    always_comb begin
        sel_msg = BLANK_MSG;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_msg = msg_t'(cc_s_q[i*10 +: 10]);
            end
        end
    end

    // Next-state logic: flush wins over terminal-count regrant, and a grant
    // at terminal count reloads the message with no blank cycle in between.
    always_comb begin
        req_s_d  = req;
        cc_s_d   = req_cc;
        state_d  = state_q;
        cnt_d    = cnt_q;
        msg_d    = msg_q;
        gnt_d    = '0;
        busy_d   = busy_q;
        owner_d  = owner_q;
        last_d   = last_q;
        do_grant = 1'b0;
        go_idle  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!flush && arb_any) begin
                    do_grant = 1'b1;
                end
            end
            ST_SHOW: begin
                if (flush) begin
                    go_idle = 1'b1;
                end else if (cnt_q == TERM) begin
                    if (arb_any) begin
                        do_grant = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (do_grant) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            msg_d   = sel_msg;
            gnt_d   = arb_win;
            busy_d  = 1'b1;
            owner_d = arb_idx;
            last_d  = arb_idx;
        end

        if (go_idle) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            msg_d   = BLANK_MSG;
            busy_d  = 1'b0;
            owner_d = '0;
        end
    end

    // State and output registers; reset blanks the display and arms requester 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            msg_q   <= BLANK_MSG;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            req_s_q <= '0;
            cc_s_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            req_s_q <= req_s_d;
            cc_s_q  <= cc_s_d;
        end
    end

    assign digit1 = msg_q.d1;
    assign digit0 = msg_q.d0;
    assign gnt    = gnt_q;
    assign busy   = busy_q;
    assign owner  = owner_q;

endmodule

// File: doc/ssd_msg_scheduler.md
SSD_MSG_SCHEDULER -- requirements
Module: ssd_msg_scheduler

Interface
REQ-001 SHALL have parameter SIMULATE, default 0; 1 selects short hold time for simulation.
REQ-002 SHALL have parameter NREQ, default 3, legal range 2..8; number of requesters.
REQ-003 SHALL have parameter HOLD_CYCLES, default (SIMULATE ? 16 : 50_000_000); display hold per granted message, in clk cycles.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  NREQ  level request per requester.
REQ-007 SHALL have port req_cc  input  NREQ x 10  per-requester message: [9:5] digit1 code, [4:0] digit0 code.
REQ-008 SHALL have port flush  input  1  synchronous abort of current message.
REQ-009 SHALL have port digit1  output  5  character code to pmodSSD_Interface digit1.
REQ-010 SHALL have port digit0  output  5  character code to pmodSSD_Interface digit0.
REQ-011 SHALL have port gnt  output  NREQ  one-hot, one-cycle grant/ack pulse.
REQ-012 SHALL have port busy  output  1  high while a message is held.
REQ-013 SHALL have port owner  output  clog2(NREQ)  index of requester currently shown; 0 when idle.

Function
REQ-014 SHALL implement FSM with states IDLE and SHOW; all outputs registered.
REQ-015 In IDLE, digit1 and digit0 SHALL equal BLANK_CC (5'h10), busy 0, gnt all 0.
REQ-016 A req sampled high in IDLE at edge n SHALL produce, after edge n+1: gnt[i]=1 for exactly one cycle, digit1/digit0 = req_cc[i] latched at edge n, owner=i, busy=1, state SHOW.
REQ-017 Winner SHALL be chosen round-robin: search starts at last_granted+1 modulo NREQ; first asserted req wins.
REQ-018 Latched message SHALL be held for exactly HOLD_CYCLES cycles, counted from the grant cycle inclusive; changes on req_cc during hold SHALL be ignored.
REQ-019 Hold counter SHALL count 0..HOLD_CYCLES-1, width clog2(HOLD_CYCLES), no wrap beyond terminal value.
REQ-020 At terminal count, if any req is high, SHALL grant next winner back-to-back (no blank cycle), including the current owner if it is the only requester.
REQ-021 At terminal count with no req, SHALL return to IDLE and blank outputs next cycle.
REQ-022 Requests SHALL NOT be latched; a req dropped before being sampled in a decision cycle SHALL receive no grant.
REQ-023 flush high in SHOW SHALL force IDLE and blank outputs next cycle; flush beats terminal-count regrant; flush in IDLE SHALL be no-op and SHALL block grant that cycle.
REQ-024 gnt SHALL never have more than one bit set.

Reset
REQ-025 reset_n low SHALL asynchronously force: state IDLE, digit1/digit0 = BLANK_CC, gnt 0, busy 0, owner 0, counter 0, last_granted = NREQ-1 (requester 0 wins first).
REQ-026 Reset asserted mid-SHOW SHALL discard the held message; no gnt pulse on release.

Structure
REQ-027 Package ssd_pkg SHALL hold BLANK_CC, cc_t (5-bit code typedef), msg_t (packed struct {cc_t d1; cc_t d0}), and sched_state_t enum.
REQ-028 Round-robin selection SHALL be a separate sub-module rr_arbiter (inputs req, last_granted; outputs one-hot winner, index, any).
REQ-029 Top SHALL be instantiable directly ahead of pmodSSD_Interface with SIMULATE passed through.

Verification (SIMULATE=1, NREQ=3, HOLD_CYCLES=16)
REQ-030 Reset, req=0 -> digit1=digit0=5'h10, busy 0 indefinitely.
REQ-031 req[1]=1 with req_cc[1]=10'h0A3 for one cycle -> gnt=3'b010 one cycle, digit1=5'h05, digit0=5'h03 for exactly 16 cycles, then blank.
REQ-032 req=3'b111 held constant -> grant order 0,1,2,0 with gnt pulses exactly 16 cycles apart, no blank gaps.
REQ-033 req[2] only, held -> regranted to 2 every 16 cycles; req_cc changes mid-hold not visible until next grant.
REQ-034 flush at hold cycle 5 with req[0] high -> blank next cycle, then regrant following flush deassert.
REQ-035 reset_n low at hold cycle 8 -> immediate blank, busy 0; after release with req=3'b110 first grant goes to requester 1.
